// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state encoding shared by the UART TX and RX blocks.
package uart_pkg;
   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_DELAY_FRAMES = 234;   // 27 MHz / 115200 baud
   localparam int BIT_IDX_W            = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } uart_state_t;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count; DEPTH must equal 2**AW.
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
   parameter int FIFO_DEPTH   = 16,
   parameter int FIFO_AW      = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_BITS-1:0] i_tx_data,
   input  logic                 i_tx_valid,
   output logic                 o_tx_ready,
   output logic                 o_uart_tx,
   output logic                 o_busy,
   output logic [FIFO_AW:0]     o_fifo_count
);
   localparam int                   CNT_W    = $clog2(DELAY_FRAMES) + 1;
   localparam logic [CNT_W-1:0]     LAST_CYC = CNT_W'(DELAY_FRAMES - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

   uart_state_t           r_state;
   logic [CNT_W-1:0]      r_cyc;
   logic [BIT_IDX_W-1:0]  r_bit;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_tx;
   logic                  r_busy;
   logic [DATA_BITS-1:0]  w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_bit_done;
   logic                  w_line;

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_tx_valid),
      .i_data  (i_tx_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifo_count)
   );

   assign w_pop      = (r_state == ST_IDLE) && !w_empty;
   assign w_bit_done = (r_cyc == LAST_CYC);
   assign o_tx_ready = !w_full;
   assign o_uart_tx  = r_tx;
   assign o_busy     = r_busy;

   always_comb begin
      w_line = 1'b1;
      case (r_state)
         ST_START:  w_line = 1'b0;
         ST_DATA:   w_line = r_shift[r_bit];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_line = even_parity(r_shift);
`endif
         default:   w_line = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cyc   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         // Line and busy both trail the state by one cycle, so busy falls as the stop bit leaves the line.
         r_tx   <= w_line;
         r_busy <= (r_state != ST_IDLE) || !w_empty;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_cyc   <= '0;
                  r_bit   <= '0;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_bit_done) begin
                  r_cyc   <= '0;
                  r_bit   <= '0;
                  r_state <= ST_DATA;
               end else r_cyc <= r_cyc + CNT_W'(1);
            end
            ST_DATA: begin
               if (w_bit_done) begin
                  r_cyc <= '0;
                  if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end else r_bit <= r_bit + BIT_IDX_W'(1);
               end else r_cyc <= r_cyc + CNT_W'(1);
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_done) begin
                  r_cyc   <= '0;
                  r_state <= ST_STOP;
               end else r_cyc <= r_cyc + CNT_W'(1);
            end
`endif
            ST_STOP: begin
               if (w_bit_done) begin
                  r_cyc   <= '0;
                  r_state <= ST_IDLE;
               end else r_cyc <= r_cyc + CNT_W'(1);
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule
